// File: rtl/pc_pkg.sv
// Next-PC select codes, default boot address and the target-alignment rule shared by the PC generator.
// No logic of its own, so there is no latency and no backpressure.
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_INC  = 3'd0,
        SEL_JUMP = 3'd1,
        SEL_RET  = 3'd2,
        SEL_TRAP = 3'd3,
        SEL_MRET = 3'd4
    } sel_e;

    localparam logic [31:0] PC_RESET_ADDR = 32'h1A00_0000;

    // With compressed instructions only byte-odd targets are illegal; otherwise word alignment is required.
    function automatic logic addr_misaligned(input logic [1:0] lo, input logic c_ext);
        return c_ext ? lo[0] : (lo != 2'b00);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; the newest entry is always visible on top_dat.
// Push/pop take effect on the next edge; a push when full overwrites the oldest entry, and a pop when empty is ignored.
module pc_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_dat,
    output logic [XLEN-1:0] top_dat,
    output logic            empty,
    output logic            full
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [XLEN-1:0] mem_d [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == DEPTH_C);
    assign top_dat = mem_q[ptr_q];
    assign do_pop  = pop && !empty;

    // ptr_q names the newest slot; the power-of-two depth makes the pointer wrap naturally.
    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (do_pop && push) begin
            mem_d[ptr_q] = push_dat;
        end else if (push) begin
            ptr_d        = ptr_q + 1'b1;
            mem_d[ptr_d] = push_dat;
            if (!full) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (do_pop) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: increment, jump, return via stack, trap and mret, with misaligned-target trapping.
// One-cycle update per enabled clock; no backpressure, ENABLE=0 freezes everything except the MISALIGN pulse.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_ADDR = XLEN'(PC_RESET_ADDR),
    parameter int              RAS_DEPTH  = 4,
    parameter bit              C_EXT      = 1'b0
) (
    input  logic            CLK,
    input  logic            RES,
    input  logic            ENABLE,
    input  logic [2:0]      SEL,
    input  logic [XLEN-1:0] D,
    input  logic [XLEN-1:0] TRAP_VEC,
    input  logic            IS_C,
    input  logic            RAS_PUSH,
    output logic [XLEN-1:0] PC_OUT,
    output logic [XLEN-1:0] EPC_OUT,
    output logic            MISALIGN,
    output logic            RAS_EMPTY
);
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] step, pc_inc, target, trap_al, ras_top;
    logic            tgt_sel, misal, ras_push, ras_pop, ras_empty, ras_full;

    always_comb begin
        step    = (C_EXT && IS_C) ? XLEN'(2) : XLEN'(4);
        pc_inc  = pc_q + step;
        trap_al = TRAP_VEC & ~XLEN'(3);

        target  = D;
        tgt_sel = 1'b0;
        case (SEL)
            SEL_JUMP: tgt_sel = 1'b1;
            SEL_RET: begin
                tgt_sel = 1'b1;
                if (!ras_empty) begin
                    target = ras_top;
                end
            end
            SEL_MRET: begin
                tgt_sel = 1'b1;
                target  = epc_q;
            end
            default: ;
        endcase
        misal = tgt_sel && addr_misaligned(target[1:0], C_EXT);

        pc_d       = pc_q;
        epc_d      = epc_q;
        misalign_d = 1'b0;
        ras_pop    = 1'b0;
        ras_push   = 1'b0;
        if (ENABLE) begin
            if (misal) begin
                pc_d       = trap_al;
                epc_d      = pc_q;
                misalign_d = 1'b1;
            end else begin
                case (SEL)
                    SEL_INC:                     pc_d = pc_inc;
                    SEL_JUMP, SEL_RET, SEL_MRET: pc_d = target;
                    SEL_TRAP: begin
                        epc_d = pc_q;
                        pc_d  = trap_al;
                    end
                    default: ;
                endcase
            end
            // A redirected (trapped) target must leave the stack untouched.
            ras_pop  = !misal && !RES && (SEL == SEL_RET) && !ras_empty;
            ras_push = !misal && !RES && RAS_PUSH && (SEL <= SEL_MRET);
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            pc_q       <= RESET_ADDR;
            epc_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            misalign_q <= misalign_d;
        end
    end

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk      (CLK),
        .rst      (RES),
        .push     (ras_push),
        .pop      (ras_pop),
        .push_dat (pc_inc),
        .top_dat  (ras_top),
        .empty    (ras_empty),
        .full     (ras_full)
    );

    a_full_not_empty: assert property (@(posedge CLK) disable iff (RES) ras_full |-> !ras_empty);

    assign PC_OUT    = pc_q;
    assign EPC_OUT   = epc_q;
    assign MISALIGN  = misalign_q;
    assign RAS_EMPTY = ras_empty;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: two instances (C_EXT=0 and C_EXT=1) share stimulus; a behavioural model fills a scoreboard.
// Expected outputs are queued when stimulus is driven and compared one cycle later, #1 after the edge.
module tb_pc_gen;
    import pc_pkg::*;

    localparam logic [31:0] RST_A = 32'h1A00_0000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        res = 1'b1, enable = 1'b0, is_c = 1'b0, ras_push = 1'b0;
    logic [2:0]  sel = 3'd0;
    logic [31:0] d = '0, trap_vec = 32'h0000_0103;
    logic [31:0] pc0, epc0, pc1, epc1;
    logic        mis0, emp0, mis1, emp1;

    always #5 clk = ~clk;

    pc_gen #(.XLEN(32), .RESET_ADDR(RST_A), .RAS_DEPTH(DEPTH), .C_EXT(1'b0)) u_dut_c0 (
        .CLK(clk), .RES(res), .ENABLE(enable), .SEL(sel), .D(d), .TRAP_VEC(trap_vec),
        .IS_C(is_c), .RAS_PUSH(ras_push), .PC_OUT(pc0), .EPC_OUT(epc0),
        .MISALIGN(mis0), .RAS_EMPTY(emp0));

    pc_gen #(.XLEN(32), .RESET_ADDR(RST_A), .RAS_DEPTH(DEPTH), .C_EXT(1'b1)) u_dut_c1 (
        .CLK(clk), .RES(res), .ENABLE(enable), .SEL(sel), .D(d), .TRAP_VEC(trap_vec),
        .IS_C(is_c), .RAS_PUSH(ras_push), .PC_OUT(pc1), .EPC_OUT(epc1),
        .MISALIGN(mis1), .RAS_EMPTY(emp1));

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        mis;
        logic        emp;
    } exp_t;

    exp_t  exp_q0[$], exp_q1[$];
    string tag_q[$];
    int    checks = 0, errors = 0;

    // Model state: m_ras[k][0] is the newest entry, shifted on every push/pop.
    logic [31:0] m_pc[2], m_epc[2];
    logic [31:0] m_ras[2][DEPTH];
    logic        m_mis[2];
    int          m_cnt[2];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int k, input bit cext);
        logic [31:0] inc, tgt, npc;
        logic        bad, pop, trapped, has_tgt;
        if (res) begin
            m_pc[k] = RST_A; m_epc[k] = '0; m_mis[k] = 1'b0; m_cnt[k] = 0;
            return;
        end
        m_mis[k] = 1'b0;
        if (!enable) return;
        inc = m_pc[k] + ((cext && is_c) ? 32'd2 : 32'd4);
        npc = m_pc[k]; tgt = d; pop = 1'b0; trapped = 1'b0; has_tgt = 1'b0;
        case (sel)
            3'd0: npc = inc;
            3'd1: has_tgt = 1'b1;
            3'd2: begin
                has_tgt = 1'b1;
                if (m_cnt[k] != 0) begin tgt = m_ras[k][0]; pop = 1'b1; end
            end
            3'd3: begin m_epc[k] = m_pc[k]; npc = {trap_vec[31:2], 2'b00}; end
            3'd4: begin has_tgt = 1'b1; tgt = m_epc[k]; end
            default: ;
        endcase
        if (has_tgt) begin
            bad = cext ? tgt[0] : (tgt[1:0] != 2'b00);
            if (bad) begin
                m_epc[k] = m_pc[k]; npc = {trap_vec[31:2], 2'b00};
                m_mis[k] = 1'b1; trapped = 1'b1; pop = 1'b0;
            end else begin
                npc = tgt;
            end
        end
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) m_ras[k][i] = m_ras[k][i+1];
            m_cnt[k]--;
        end
        if (ras_push && sel <= 3'd4 && !trapped) begin
            for (int i = DEPTH - 1; i > 0; i--) m_ras[k][i] = m_ras[k][i-1];
            m_ras[k][0] = inc;
            if (m_cnt[k] < DEPTH) m_cnt[k]++;
        end
        m_pc[k] = npc;
    endtask

    task automatic compare_out();
        exp_t  e0, e1;
        string t;
        check_eq("sb_depth", 64'(tag_q.size()), 64'd1);
        if (tag_q.size() == 0) return;
        t  = tag_q.pop_front();
        e0 = exp_q0.pop_front();
        e1 = exp_q1.pop_front();
        check_eq({t, ".pc_c0"},  64'(pc0),  64'(e0.pc));
        check_eq({t, ".epc_c0"}, 64'(epc0), 64'(e0.epc));
        check_eq({t, ".mis_c0"}, 64'(mis0), 64'(e0.mis));
        check_eq({t, ".emp_c0"}, 64'(emp0), 64'(e0.emp));
        check_eq({t, ".pc_c1"},  64'(pc1),  64'(e1.pc));
        check_eq({t, ".epc_c1"}, 64'(epc1), 64'(e1.epc));
        check_eq({t, ".mis_c1"}, 64'(mis1), 64'(e1.mis));
        check_eq({t, ".emp_c1"}, 64'(emp1), 64'(e1.emp));
    endtask

    task automatic cycle(input string tag, input logic r, input logic en, input logic [2:0] s,
                         input logic [31:0] dd, input logic ic, input logic pu);
        res = r; enable = en; sel = s; d = dd; is_c = ic; ras_push = pu;
        model_step(0, 1'b0);
        model_step(1, 1'b1);
        exp_q0.push_back('{pc: m_pc[0], epc: m_epc[0], mis: m_mis[0], emp: (m_cnt[0] == 0)});
        exp_q1.push_back('{pc: m_pc[1], epc: m_epc[1], mis: m_mis[1], emp: (m_cnt[1] == 0)});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        // Reset together with a pending trap: reset wins.
        cycle("rst_trap", 1, 1, 3'd3, 32'h0, 0, 0);
        cycle("inc1", 0, 1, 3'd0, 32'h0, 0, 0);
        cycle("inc2", 0, 1, 3'd0, 32'h0, 0, 0);
        cycle("inc3", 0, 1, 3'd0, 32'h0, 0, 0);
        cycle("en_off", 0, 0, 3'd1, 32'h0, 0, 1);
        cycle("inc4", 0, 1, 3'd0, 32'h0, 0, 0);
        cycle("trap", 0, 1, 3'd3, 32'h0, 0, 0);
        cycle("mret", 0, 1, 3'd4, 32'h0, 0, 0);

        // Compressed step and misaligned jump.
        cycle("rst2", 1, 0, 3'd0, 32'h0, 0, 0);
        cycle("inc_c", 0, 1, 3'd0, 32'h0, 1, 0);
        cycle("jmp_odd", 0, 1, 3'd1, 32'h1A00_0101, 0, 0);
        cycle("mis_clr", 0, 1, 3'd0, 32'h0, 0, 0);
        cycle("jmp_half", 0, 1, 3'd1, 32'h1A00_0202, 0, 1);
        cycle("mret_half", 0, 1, 3'd4, 32'h0, 0, 0);

        // Five calls into a four-deep stack, then five returns.
        cycle("rst3", 1, 1, 3'd0, 32'h0, 0, 0);
        for (int i = 0; i < 5; i++)
            cycle($sformatf("call%0d", i), 0, 1, 3'd1, 32'h2000_0000 + 32'(i) * 32'h100, 0, 1);
        for (int i = 0; i < 5; i++)
            cycle($sformatf("ret%0d", i), 0, 1, 3'd2, 32'h3000_0000, 0, 0);

        // Co-routine swap: pop and push in the same cycle.
        cycle("co_call0", 0, 1, 3'd1, 32'h4000_0000, 0, 1);
        cycle("co_call1", 0, 1, 3'd1, 32'h4000_0100, 0, 1);
        cycle("co_ret", 0, 1, 3'd2, 32'h0, 0, 1);
        cycle("co_pop0", 0, 1, 3'd2, 32'h0, 0, 0);
        cycle("co_pop1", 0, 1, 3'd2, 32'h0, 0, 0);
        cycle("pop_empty", 0, 1, 3'd2, 32'h5000_0000, 0, 0);

        // MISALIGN drops while stalled; wrap at the top of the address space; hold codes.
        cycle("jmp_mis", 0, 1, 3'd1, 32'h5000_0001, 0, 1);
        cycle("stall_mis", 0, 0, 3'd0, 32'h0, 0, 0);
        cycle("jmp_top", 0, 1, 3'd1, 32'hFFFF_FFFC, 0, 0);
        cycle("wrap", 0, 1, 3'd0, 32'h0, 0, 0);
        cycle("hold5", 0, 1, 3'd5, 32'h1234_5678, 0, 1);
        cycle("hold6", 0, 1, 3'd6, 32'h1234_5678, 1, 1);
        cycle("hold7", 0, 1, 3'd7, 32'h1234_5678, 0, 1);
        cycle("call_pre", 0, 1, 3'd1, 32'h6000_0000, 0, 1);
        cycle("rst_pend", 1, 1, 3'd1, 32'h7000_0000, 0, 1);

        // Random mix, including occasional resets and trap-vector changes.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) trap_vec = $urandom;
            cycle($sformatf("rnd%0d", i), ($urandom_range(0, 29) == 0), ($urandom_range(0, 7) != 0),
                  3'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
